instr_aligner: RTL and testbench

INSTR_ALIGNER -- requirements
Module: instr_aligner

---
 rtl/instr_aligner.sv | 130 +++++++++++++
 tb/tb_instr_aligner.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_aligner.sv
// rtl/instr_aligner.sv - fetch-word to instruction aligner with optional RVC parcel handling
//
// Purpose: buffers 32-bit fetch words as 16-bit parcels and presents complete
// instructions to the decoder. A 32-bit instruction may straddle two fetch words.
// Optional feature macro: RV32C_EN. When it is defined, compressed (16-bit)
// instructions are recognised. When it is undefined, every instruction is one
// 32-bit word.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush, flush_pc     redirect: discard buffer; flush_pc[1] selects start halfword
//   fetch_valid/ready   fetch word handshake
//   fetch_data/pc       fetched word (little-endian halfwords) and its word address
//   dec_valid/ready     decoder handshake
//   dec_instr/pc        instruction (compressed form zero-extended) and its address
//   dec_compressed      dec_instr is a 16-bit parcel
module instr_aligner #(
  parameter int PARCELS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  input  logic [31:0] fetch_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        dec_compressed
);
  localparam int          AW    = $clog2(PARCELS);
  localparam logic [AW:0] DEPTH = (AW+1)'(PARCELS);

  // The storage is parcel-based in both builds. Without RVC, every push and pop
  // moves two parcels, so the queue behaves as a PARCELS/2-deep word queue.
  logic [15:0]   par_q [PARCELS];
  logic [31:0]   pc_q  [PARCELS];

  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic          drop_low_q, drop_low_d;
  logic [AW:0]   used, free, need;
  logic [AW-1:0] wr_idx, wr_nxt, rd_idx, rd_nxt;
  logic [15:0]   head, tail;
  logic          head_c, accept, push_low, pop;
  logic          unused_flush_pc;

  assign used   = wr_q - rd_q;
  assign free   = DEPTH - used;
  assign wr_idx = wr_q[AW-1:0];
  assign wr_nxt = wr_idx + AW'(1);
  assign rd_idx = rd_q[AW-1:0];
  assign rd_nxt = rd_idx + AW'(1);
  assign head   = par_q[rd_idx];
  assign tail   = par_q[rd_nxt];

`ifdef RV32C_EN
  assign head_c          = (head[1:0] != 2'b11);
  assign fetch_ready     = (free >= (AW+1)'(2)) && !flush;
  assign unused_flush_pc = ^{flush_pc[31:2], flush_pc[0]};
`else
  assign head_c          = 1'b0;
  assign fetch_ready     = (used != DEPTH) && !flush;
  assign unused_flush_pc = ^flush_pc;
`endif

  assign need     = head_c ? (AW+1)'(1) : (AW+1)'(2);
  // The "used >= need" test also covers a 32-bit head whose upper half has not arrived yet.
  assign dec_valid = (used >= need);
  assign accept   = fetch_valid && fetch_ready;
  assign push_low = accept && !drop_low_q;
  assign pop      = dec_valid && dec_ready && !flush;

  assign dec_instr      = !dec_valid ? 32'h0 : (head_c ? {16'h0, head} : {tail, head});
  assign dec_pc         = dec_valid ? pc_q[rd_idx] : 32'h0;
  assign dec_compressed = dec_valid && head_c;

  always_comb begin
    wr_d       = wr_q;
    rd_d       = rd_q;
    drop_low_d = drop_low_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
`ifdef RV32C_EN
      drop_low_d = flush_pc[1];
`else
      drop_low_d = 1'b0;
`endif
    end else begin
      if (accept) begin
        wr_d       = wr_q + (push_low ? (AW+1)'(2) : (AW+1)'(1));
        drop_low_d = 1'b0;
      end
      if (pop) begin
        rd_d = rd_q + need;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q       <= '0;
      rd_q       <= '0;
      drop_low_q <= 1'b0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      drop_low_q <= drop_low_d;
    end
  end

  // Parcel storage needs no reset because the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (push_low) begin
        par_q[wr_idx] <= fetch_data[15:0];
        pc_q[wr_idx]  <= fetch_pc;
        par_q[wr_nxt] <= fetch_data[31:16];
        pc_q[wr_nxt]  <= fetch_pc + 32'd2;
      end else begin
        par_q[wr_idx] <= fetch_data[31:16];
        pc_q[wr_idx]  <= fetch_pc + 32'd2;
      end
    end
  end

endmodule

// File: tb/tb_instr_aligner.sv
// tb/tb_instr_aligner.sv - randomized self-checking bench for instr_aligner
module tb_instr_aligner;
  localparam int PARCELS = 8;
`ifdef RV32C_EN
  localparam bit C_EN = 1'b1;
`else
  localparam bit C_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] flush_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic [31:0] fetch_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_compressed;

  instr_aligner #(.PARCELS(PARCELS)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_data(fetch_data), .fetch_pc(fetch_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .dec_compressed(dec_compressed)
  );

  always #5 clk = ~clk;

  // Reference model. With RVC, each entry is a parcel (data in [15:0]).
  // Without RVC, each entry is a whole word.
  typedef struct { logic [31:0] d; logic [31:0] pc; } ent_t;
  ent_t        mq[$];
  bit          m_drop;
  logic [31:0] nxt_pc;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_out(output bit v, output logic [31:0] ins, output logic [31:0] pc,
                           output bit c, output int need, output bit rdy);
    v = 0; ins = 0; pc = 0; c = 0; need = 0;
    if (C_EN) begin
      rdy = (PARCELS - mq.size()) >= 2;
      if (mq.size() > 0) begin
        need = (mq[0].d[1:0] != 2'b11) ? 1 : 2;
        if (mq.size() >= need) begin
          v   = 1;
          c   = (need == 1);
          pc  = mq[0].pc;
          ins = c ? {16'h0, mq[0].d[15:0]} : {mq[1].d[15:0], mq[0].d[15:0]};
        end
      end
    end else begin
      rdy = mq.size() < PARCELS / 2;
      if (mq.size() > 0) begin
        need = 1; v = 1; pc = mq[0].pc; ins = mq[0].d;
      end
    end
  endtask

  // One clock cycle: drive the inputs, check the outputs against the model, then advance the model.
  task automatic step(input bit fv, input logic [31:0] fd, input logic [31:0] fpc,
                      input bit dr, input bit fl, input logic [31:0] flpc);
    bit v, c, rdy;
    logic [31:0] ins, pc;
    int need;
    fetch_valid = fv; fetch_data = fd; fetch_pc = fpc;
    dec_ready = dr; flush = fl; flush_pc = flpc;
    #1;
    model_out(v, ins, pc, c, need, rdy);
    rdy = rdy && !fl;
    check("dec_valid", {31'b0, dec_valid}, {31'b0, v});
    check("dec_instr", dec_instr, ins);
    check("dec_pc", dec_pc, pc);
    check("dec_compressed", {31'b0, dec_compressed}, {31'b0, c});
    check("fetch_ready", {31'b0, fetch_ready}, {31'b0, rdy});
    @(posedge clk);
    if (fl) begin
      mq.delete();
      m_drop = C_EN && flpc[1];
      nxt_pc = flpc & ~32'h3;
    end else begin
      if (v && dr) repeat (need) void'(mq.pop_front());
      if (fv && rdy) begin
        nxt_pc = fpc + 4;
        if (!C_EN) mq.push_back('{d: fd, pc: fpc});
        else begin
          if (!m_drop) mq.push_back('{d: {16'h0, fd[15:0]}, pc: fpc});
          mq.push_back('{d: {16'h0, fd[31:16]}, pc: fpc + 2});
          m_drop = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit dr);
    step(1'b0, 32'h0, 32'h0, dr, 1'b0, 32'h0);
  endtask

  initial begin
    rst_n = 0; flush = 0; flush_pc = 0; fetch_valid = 0; fetch_data = 0;
    fetch_pc = 0; dec_ready = 0; m_drop = 0; nxt_pc = 0;
    #1;
    check("rst_dec_valid", {31'b0, dec_valid}, 32'h0);
    check("rst_dec_instr", dec_instr, 32'h0);
    check("rst_dec_pc", dec_pc, 32'h0);
    check("rst_dec_comp", {31'b0, dec_compressed}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    check("rst_fetch_ready", {31'b0, fetch_ready}, 32'h1);
    @(negedge clk);

    // Single 32-bit instruction, visible exactly one cycle after it is accepted
    step(1, 32'h00A00093, 32'h0, 0, 0, 0);
    check("r030_valid", {31'b0, dec_valid}, 32'h1);
    check("r030_instr", dec_instr, 32'h00A00093);
    check("r030_pc", dec_pc, 32'h0);
    check("r030_comp", {31'b0, dec_compressed}, 32'h0);
    idle(1);
    check("r030_drained", {31'b0, dec_valid}, 32'h0);

    // Two compressed instructions in one fetch word
    step(1, 32'h45014501, 32'h100, 0, 0, 0);
`ifdef RV32C_EN
    check("r031_instr0", dec_instr, 32'h00004501);
    check("r031_pc0", dec_pc, 32'h100);
    check("r031_comp0", {31'b0, dec_compressed}, 32'h1);
    idle(1);
    check("r031_pc1", dec_pc, 32'h102);
    check("r031_comp1", {31'b0, dec_compressed}, 32'h1);
`endif
    repeat (2) idle(1);

    // A 32-bit instruction that straddles two fetch words
    step(1, 32'h00934505, 32'h200, 0, 0, 0);
`ifdef RV32C_EN
    check("r032_instr0", dec_instr, 32'h00004505);
    idle(1);
    check("r032_wait", {31'b0, dec_valid}, 32'h0);
    step(1, 32'h000000A0, 32'h204, 0, 0, 0);
    check("r032_instr1", dec_instr, 32'h00A00093);
    check("r032_pc1", dec_pc, 32'h202);
`endif
    repeat (3) idle(1);

    // Back-pressure: fill the queue until fetch_ready drops, then drain it and check the order
    for (int i = 0; i < PARCELS; i++) step(1, $urandom, nxt_pc, 0, 0, 0);
    #1;
    check("r033_full_ready", {31'b0, fetch_ready}, 32'h0);
    for (int i = 0; i < PARCELS + 2; i++) idle(1);

    // A flush with a fetch in the same cycle, restarting at the upper halfword
    step(1, 32'h00010001, 32'h400, 0, 0, 0);
    step(1, 32'hDEADBEEF, 32'h404, 1, 1, 32'h302);
    check("r034_empty", {31'b0, dec_valid}, 32'h0);
    step(1, 32'h12345678, 32'h300, 0, 0, 0);
`ifdef RV32C_EN
    check("r034_instr", dec_instr, 32'h00001234);
    check("r034_pc", dec_pc, 32'h302);
    check("r034_comp", {31'b0, dec_compressed}, 32'h1);
`else
    check("r034_instr", dec_instr, 32'h12345678);
    check("r034_pc", dec_pc, 32'h300);
`endif
    repeat (2) idle(1);

    // Reset asserted while a straddling instruction is half buffered
    step(1, 32'h00934505, 32'h200, 1, 0, 0);
    idle(1);
    rst_n = 0;
    #1;
    check("r035_valid", {31'b0, dec_valid}, 32'h0);
    check("r035_instr", dec_instr, 32'h0);
    check("r035_pc", dec_pc, 32'h0);
    check("r035_comp", {31'b0, dec_compressed}, 32'h0);
    mq.delete(); m_drop = 0;
    @(negedge clk);
    rst_n = 1;
    step(1, 32'h00A00093, 32'h0, 0, 0, 0);
    check("r035_after", dec_instr, 32'h00A00093);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit fl;
      fl = ($urandom_range(0, 31) == 0);
      step($urandom_range(0, 3) != 0, $urandom, nxt_pc, $urandom_range(0, 2) != 0,
           fl, $urandom & 32'hFFFF_FFFE);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
